// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared types and constants for the UART transmit scheduler.
//   state_t           scheduler FSM states
//   DEF_LOCK_TIMEOUT  default stall cycles before a mid-frame grant is revoked
//   DEF_BUSY_WAIT     default cycles to wait for the transmitter to go busy
//   clog2()           ceil(log2(v)), never less than 1
package uart_tx_sched_pkg;

   typedef enum logic [2:0] {IDLE, ISSUE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

   localparam int DEF_LOCK_TIMEOUT = 1024;
   localparam int DEF_BUSY_WAIT    = 4;

   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_valid   request vector
//   i_ptr     index that has highest priority this round
//   o_onehot  one-hot winner (zero when no request)
//   o_idx     binary index of the winner
module rr_pick
   import uart_tx_sched_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx
);

   int w_best;
   int w_dist;

   // Winner is the valid requester at the smallest circular distance from i_ptr.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_best   = N;
      w_dist   = 0;
      for (int k = 0; k < N; k++) begin
         w_dist = (k + N - int'(i_ptr)) % N;
         if (i_valid[k] && w_dist < w_best) begin
            w_best      = w_dist;
            o_idx       = IW'(k);
            o_onehot    = '0;
            o_onehot[k] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between N_REQ byte-stream requesters,
// arbitrating per frame and sequencing the transmitter send/ready handshake.
//   i_wb_clk, i_wb_rst_n          clock, async active-low reset
//   i_req_valid/data/last         per-requester byte stream (data k at [8k+7:8k])
//   o_req_ready                   byte of requester k accepted this cycle
//   o_tx_data, o_tx_send          registered byte and one-cycle send strobe
//   i_tx_ready                    transmitter idle
//   o_grant, o_busy               one-hot owner, FSM not idle
//   o_timeout, i_timeout_clr      sticky grant-revoked flag and its clear
// Build option: define UART_TX_SCHED_PRIO_EN to give requester 0 absolute
// priority at frame boundaries; otherwise pure round-robin.
module uart_tx_sched
   import uart_tx_sched_pkg::*;
#(
   parameter int N_REQ        = 3,
   parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
   parameter int BUSY_WAIT    = DEF_BUSY_WAIT
) (
   input  logic               i_wb_clk,
   input  logic               i_wb_rst_n,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [8*N_REQ-1:0] i_req_data,
   input  logic [N_REQ-1:0]   i_req_last,
   output logic [N_REQ-1:0]   o_req_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_send,
   input  logic               i_tx_ready,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_busy,
   output logic               o_timeout,
   input  logic               i_timeout_clr
);

   localparam int IW = clog2(N_REQ);
   localparam int TW = clog2(LOCK_TIMEOUT + 1);
   localparam int BW = clog2(BUSY_WAIT + 1);
   localparam logic [N_REQ-1:0] REQ0 = 1;

   state_t           r_state, w_next;
   logic [N_REQ-1:0] r_grant, w_pick_valid, w_win;
   logic [IW-1:0]    r_gidx, r_ptr, w_win_idx, w_ptr_next;
   logic [7:0]       r_tx_data;
   logic             r_last, r_timeout;
   logic [TW-1:0]    r_stall;
   logic [BW-1:0]    r_bw;
   logic             w_valid_g, w_accept, w_revoke, w_done;

`ifdef UART_TX_SCHED_PRIO_EN
   // Requester 0 alone when it is valid; otherwise round-robin over the rest.
   assign w_pick_valid = i_req_valid[0] ? REQ0 : (i_req_valid & ~REQ0);
`else
   assign w_pick_valid = i_req_valid;
`endif

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .i_valid  (w_pick_valid),
      .i_ptr    (r_ptr),
      .o_onehot (w_win),
      .o_idx    (w_win_idx)
   );

   assign w_valid_g  = i_req_valid[r_gidx];
   assign w_accept   = |o_req_ready;
   assign w_revoke   = r_state == ISSUE && !w_valid_g && r_stall == TW'(LOCK_TIMEOUT - 1);
   assign w_done     = r_state == WAIT_DONE && i_tx_ready && r_last;
   assign w_ptr_next = (r_gidx == IW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) r_state <= IDLE;
      else             r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      w_next = |i_req_valid ? ISSUE : IDLE;
         ISSUE:     w_next = w_accept ? SEND : (w_revoke ? IDLE : ISSUE);
         SEND:      w_next = WAIT_BUSY;
         // A transmitter that never drops ready is treated as already done.
         WAIT_BUSY: w_next = (!i_tx_ready || r_bw == BW'(BUSY_WAIT - 1)) ? WAIT_DONE : WAIT_BUSY;
         WAIT_DONE: w_next = i_tx_ready ? (r_last ? IDLE : ISSUE) : WAIT_DONE;
         default:   w_next = IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = (r_state == ISSUE && i_tx_ready) ? (r_grant & i_req_valid) : '0;
      o_tx_send   = r_state == SEND;
      o_busy      = r_state != IDLE;
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         r_grant   <= '0;
         r_gidx    <= '0;
         r_ptr     <= '0;
         r_tx_data <= '0;
         r_last    <= 1'b0;
         r_stall   <= '0;
         r_bw      <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (r_state == IDLE && |i_req_valid) begin
            r_grant <= w_win;
            r_gidx  <= w_win_idx;
         end else if (w_done || w_revoke) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
         end
         if (w_accept) begin
            r_tx_data <= i_req_data[8*r_gidx +: 8];
            r_last    <= i_req_last[r_gidx];
         end
         r_stall   <= (r_state != ISSUE || w_accept || w_revoke) ? '0 :
                      (!w_valid_g ? r_stall + 1'b1 : r_stall);
         r_bw      <= (r_state == WAIT_BUSY) ? r_bw + 1'b1 : '0;
         // A revoke in the same cycle as a clear leaves the flag set.
         r_timeout <= w_revoke | (r_timeout & ~i_timeout_clr);
      end
   end

   assign o_grant   = r_grant;
   assign o_tx_data = r_tx_data;
   assign o_timeout = r_timeout;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Scheduler that shares the single UART serial transmitter between several byte-stream requesters (CPU register path, high-priority output-buffer path, debug/trace path). It arbitrates per frame, holds the grant until the requester marks its last byte, and sequences the transmitter's send/ready handshake. It sits between the requesters and the transmitter inside the UART peripheral, on the Wishbone clock.

## Interface
- N_REQ, 3: number of requesters (2..8); index 0 is the high-priority path.
- LOCK_TIMEOUT, 1024: idle cycles a granted requester may stall mid-frame before the grant is revoked.
- BUSY_WAIT, 4: cycles to wait for transmitter ready to drop after a send pulse.

- i_wb_clk  in  1  clock.
- i_wb_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  N_REQ  requester k has a byte.
- i_req_data  in  8*N_REQ  byte of requester k in bits [8k+7:8k].
- i_req_last  in  N_REQ  byte of requester k closes its frame.
- o_req_ready  out  N_REQ  byte of requester k accepted this cycle.
- o_tx_data  out  8  byte to transmitter, registered.
- o_tx_send  out  1  one-cycle send strobe to transmitter.
- i_tx_ready  in  1  transmitter idle.
- o_grant  out  N_REQ  one-hot current owner; zero when idle.
- o_busy  out  1  state is not IDLE.
- o_timeout  out  1  sticky: a grant was revoked by timeout.
- i_timeout_clr  in  1  clears o_timeout.

## Operation
- States: IDLE, ISSUE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if any i_req_valid, pick winner and register o_grant; go to ISSUE. Round-robin search starts at rr_ptr, the index after the previous winner.
- ISSUE: o_req_ready[g] = i_req_valid[g] & i_tx_ready (combinational; zero for all other k). On accept: latch data into o_tx_data, latch i_req_last into last_q, go to SEND.
- ISSUE with i_req_valid[g] low: count stall cycles. At LOCK_TIMEOUT: clear grant, set o_timeout, rr_ptr = g+1, go to IDLE. The counter clears on every accept.
- SEND: o_tx_send=1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_DONE when i_tx_ready=0. After BUSY_WAIT cycles without that, go to WAIT_DONE anyway, treating the send as already complete.
- WAIT_DONE: wait for i_tx_ready=1. Then, if last_q: clear grant, rr_ptr = g+1 mod N_REQ, go to IDLE. Otherwise go to ISSUE with the grant held.
- Grant is never taken away mid-frame except by timeout.
- o_timeout: set by revoke, cleared by i_timeout_clr. If both happen in the same cycle, set wins.

## Timing
- Reset (async, any state): state IDLE; o_grant=0, o_tx_send=0, o_tx_data=0, o_busy=0, o_timeout=0, o_req_ready=0, rr_ptr=0, counters 0. An in-flight byte is abandoned and no strobe follows.
- Valid in IDLE at cycle t: o_grant at t+1. Earliest accept at t+1, o_tx_send at t+2.
- Accept at cycle a: o_tx_send and stable o_tx_data at a+1. o_tx_data holds until the next accept.
- Back-to-back bytes in a frame: next accept occurs in the cycle after i_tx_ready returns to 1 in WAIT_DONE.
- Requester valid and data must hold until ready. Dropping valid before accept is legal and counts as a stall.
- Simultaneous valids in IDLE: exactly one grant. Pointer wraps from N_REQ-1 to 0.

## Configuration
- UART_TX_SCHED_PRIO_EN defined: in IDLE, requester 0 wins whenever valid, and round-robin applies only among 1..N_REQ-1. A frame in progress is still never pre-empted.
- Not defined: pure round-robin over all requesters.

## Structure
- Package uart_tx_sched_pkg holds the state enum, the default LOCK_TIMEOUT/BUSY_WAIT constants and the clog2 function.
- Sub-module rr_pick: combinational round-robin picker taking valid vector and pointer, producing one-hot winner and index. It is reused by the PRIO_EN masking.

## Test plan
- Single byte: req1 sends 0x41 with last=1, transmitter drops ready 2 cycles after the strobe and raises it 10 cycles later -> exactly one o_tx_send with o_tx_data=0x41; o_grant returns to 0 after ready returns.
- Frame lock: req2 sends a 3-byte frame 0x10,0x11,0x12 while req0 is valid throughout -> all three req2 bytes go out before any req0 byte (PRIO_EN both on and off).
- Fairness: all requesters continuously sending single-byte frames, PRIO_EN off -> grant order 0,1,2,0,1,2. PRIO_EN on -> 0 after every frame.
- Timeout: req1 sends 0x55 with last=0, then drops valid for LOCK_TIMEOUT cycles -> grant revoked, o_timeout=1, and req2 is served next. i_timeout_clr clears o_timeout.
- Stuck-ready transmitter: i_tx_ready held at 1 -> each byte advances after BUSY_WAIT cycles with one strobe per byte.
- Reset mid-frame: deassert i_wb_rst_n during WAIT_BUSY -> all outputs 0 immediately; no strobe after reset release until a new valid arrives.
